// File: rtl/rsa_uart_pkg.sv
// Shared encodings and defaults for the UART receive word packer.
// Optional msg_bytes counter: define UART_RX_MSG_BYTE_COUNT_EN.
package rsa_uart_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_ACK     = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  typedef enum logic [1:0] {
    COLLECT = ST_COLLECT,
    ACK     = ST_ACK,
    EMIT    = ST_EMIT
  } state_t;

  localparam logic [7:0] ASCII_EOT = 8'h04;
  localparam int DEF_WORD_BYTES = 4;

endpackage

// File: rtl/byte_lane_writer.sv
// Inserts one byte into lane idx of a big-endian word, or zero-clears it.
// Lane 0 is the MSB byte.
module byte_lane_writer
  import rsa_uart_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic [7:0]              lane_byte,
  input  logic [CNT_W-1:0]        lane_idx,
  input  logic                    wr_en,
  input  logic                    clr,
  output logic [8*WORD_BYTES-1:0] word_out
);

  always_comb begin
    word_out = word_in;
    if (clr) begin
      word_out = '0;
    end else if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane_idx == CNT_W'(i)) begin
          word_out[8*(WORD_BYTES-1-i) +: 8] = lane_byte;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Drains the UART receive buffer and packs bytes big-endian into words.
// Optional msg_bytes counter: define UART_RX_MSG_BYTE_COUNT_EN.
module uart_rx_word_packer
  import rsa_uart_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_flag,
  input  logic                    rx_eot,
  input  logic [7:0]              rx_data,
  output logic                    rx_clear,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    word_last,
  output logic [CNT_W-1:0]        word_nbytes,
  output logic                    busy
`ifdef UART_RX_MSG_BYTE_COUNT_EN
  ,
  output logic [15:0]             msg_bytes
`endif
);

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [8*WORD_BYTES-1:0] word_nxt;
  logic                    last_pending;
  logic                    cap;
  logic                    acc;

  assign cap  = (state == COLLECT) && rx_flag && !rx_eot;
  assign acc  = (state == EMIT) && word_ready;
  assign busy = (state == EMIT) || (count != '0);

  byte_lane_writer #(
    .WORD_BYTES (WORD_BYTES),
    .CNT_W      (CNT_W)
  ) u_lane (
    .word_in   (word_q),
    .lane_byte (rx_data),
    .lane_idx  (count),
    .wr_en     (cap),
    .clr       (acc),
    .word_out  (word_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      count        <= '0;
      word_q       <= '0;
      last_pending <= 1'b0;
      rx_clear     <= 1'b0;
      word_valid   <= 1'b0;
      word_last    <= 1'b0;
      word_nbytes  <= '0;
      word_data    <= '0;
    end else begin
      word_q <= word_nxt;
      unique case (state)
        COLLECT: begin
          if (rx_flag) begin
            if (!rx_eot) begin
              count <= count + CNT_W'(1);
            end else begin
              last_pending <= 1'b1;
            end
            rx_clear <= 1'b1;
            state    <= ACK;
          end
        end
        // The buffer flag is still set here; it is deliberately ignored.
        ACK: begin
          rx_clear <= 1'b0;
          if (last_pending || count == CNT_W'(WORD_BYTES)) begin
            word_valid  <= 1'b1;
            word_last   <= last_pending;
            word_nbytes <= count;
            word_data   <= word_q;
            state       <= EMIT;
          end else begin
            state <= COLLECT;
          end
        end
        EMIT: begin
          if (word_ready) begin
            word_valid   <= 1'b0;
            word_last    <= 1'b0;
            word_nbytes  <= '0;
            word_data    <= '0;
            count        <= '0;
            last_pending <= 1'b0;
            state        <= COLLECT;
          end
        end
        default: begin
          rx_clear <= 1'b0;
          state    <= COLLECT;
        end
      endcase
    end
  end

`ifdef UART_RX_MSG_BYTE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_bytes <= '0;
    end else if (acc && word_last) begin
      msg_bytes <= '0;
    end else if (cap && msg_bytes != 16'hFFFF) begin
      msg_bytes <= msg_bytes + 16'd1;
    end
  end
`endif

endmodule
